// File: rtl/addsub_chunk_seq.sv
// Streams NUM_CHUNKS chunks, LSB first, through an external ADDSUB and chains carry/borrow between them.
// Result valid NUM_CHUNKS cycles after accept; holds result until resp_ready_i; req_ready_o low while busy.
module addsub_chunk_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                             module_clk_i,
  input  logic                             module_rst_i,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [DATA_WIDTH*NUM_CHUNKS-1:0] op_a_i,
  input  logic [DATA_WIDTH*NUM_CHUNKS-1:0] op_b_i,
  input  logic                             sub_i,
  input  logic                             carry_in_i,
  output logic                             resp_valid_o,
  input  logic                             resp_ready_i,
  output logic [DATA_WIDTH*NUM_CHUNKS-1:0] result_o,
  output logic                             carry_out_o,
  output logic                             add_en_o,
  output logic [DATA_WIDTH-1:0]            add_a_o,
  output logic [DATA_WIDTH-1:0]            add_b_o,
  output logic                             add_ci_o,
  output logic                             add_sub_o,
  input  logic [DATA_WIDTH-1:0]            add_sum_i,
  input  logic                             add_co_i
);

  localparam int OP_W  = DATA_WIDTH * NUM_CHUNKS;
  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [OP_W-1:0]  a_q;
  logic [OP_W-1:0]  b_q;
  logic             sub_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             last_chunk;

  assign run        = (state == RUN);
  assign last_chunk = (cnt == CNT_W'(NUM_CHUNKS - 1));

  // Operands are gated to zero outside RUN so the shared adder stays quiet.
  assign add_en_o  = run;
  assign add_a_o   = run ? a_q[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign add_b_o   = run ? b_q[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign add_ci_o  = run ? carry_q : 1'b0;
  assign add_sub_o = sub_q;

  always_ff @(posedge module_clk_i) begin
    if (module_rst_i) begin
      state        <= IDLE;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      result_o     <= '0;
      carry_out_o  <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      carry_q      <= 1'b0;
      cnt          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            a_q         <= op_a_i;
            b_q         <= op_b_i;
            sub_q       <= sub_i;
            carry_q     <= carry_in_i;
            cnt         <= '0;
            req_ready_o <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          result_o[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= add_sum_i;
          carry_q <= add_co_i;
          cnt     <= cnt + 1'b1;
          if (last_chunk) begin
            carry_out_o  <= add_co_i;
            resp_valid_o <= 1'b1;
            cnt          <= '0;
            state        <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE first guarantees no accept on the handshake edge.
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_chunk_seq.sv
// Bench for addsub_chunk_seq with an 8-bit behavioural ADDSUB closing the loop.
module tb_addsub_chunk_seq;

  localparam int DW   = 8;
  localparam int NC   = 4;
  localparam int OP_W = DW * NC;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            sub;
  logic            cin;
  logic            resp_valid;
  logic            resp_ready;
  logic [OP_W-1:0] result;
  logic            carry_out;
  logic            add_en;
  logic [DW-1:0]   add_a;
  logic [DW-1:0]   add_b;
  logic            add_ci;
  logic            add_sub;
  logic [DW-1:0]   add_sum;
  logic            add_co;
  logic [DW:0]     add_tmp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // ADDSUB: add gives carry-out, sub gives borrow-out in the top bit.
  always_comb begin
    add_tmp = '0;
    if (add_sub) add_tmp = {1'b0, add_a} - {1'b0, add_b} - {{DW{1'b0}}, add_ci};
    else         add_tmp = {1'b0, add_a} + {1'b0, add_b} + {{DW{1'b0}}, add_ci};
  end
  assign add_sum = add_tmp[DW-1:0];
  assign add_co  = add_tmp[DW];

  addsub_chunk_seq #(.DATA_WIDTH(DW), .NUM_CHUNKS(NC)) dut (
    .module_clk_i (clk),
    .module_rst_i (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .sub_i        (sub),
    .carry_in_i   (cin),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .result_o     (result),
    .carry_out_o  (carry_out),
    .add_en_o     (add_en),
    .add_a_o      (add_a),
    .add_b_o      (add_b),
    .add_ci_o     (add_ci),
    .add_sub_o    (add_sub),
    .add_sum_i    (add_sum),
    .add_co_i     (add_co)
  );

  typedef struct {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            sub;
    logic            cin;
    logic [OP_W-1:0] exp_res;
    logic            exp_co;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                       input logic s, input logic c);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
    op_a = a; op_b = b; sub = s; cin = c; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Called at the negedge just after the accept edge.
  task automatic finish_op(input logic [OP_W-1:0] a, input logic c,
                           input logic s, input vec_t v);
    int lat;
    chk("run_en", {31'b0, add_en}, 32'd1);
    chk("run_chunk0", {23'b0, add_ci, add_a}, {23'b0, c, a[DW-1:0]});
    chk("run_ready_low", {31'b0, req_ready}, 32'd0);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, NC);
    chk("result", result, v.exp_res);
    chk("carry_out", {31'b0, carry_out}, {31'b0, v.exp_co});
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_hs", {29'b0, resp_valid, req_ready, add_sub}, {29'b0, 1'b0, 1'b1, s});
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.a, v.b, v.sub, v.cin);
    finish_op(v.a, v.cin, v.sub, v);
  endtask

  initial begin
    vec_t w;
    vecs[0] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 1'b0};
    vecs[3] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{32'h1234_5678, 32'h0204_0608, 1'b1, 1'b0, 32'h1030_5070, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[6] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b1, 32'h0000_0000, 1'b1};

    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    op_a = '0; op_b = '0; sub = 1'b0; cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_handshake", {30'b0, req_ready, resp_valid}, 32'h2);
    chk("reset_result", result, 32'h0);
    chk("reset_adder", {21'b0, carry_out, add_en, add_ci, add_sub, add_a}, 32'h0);
    chk("reset_add_b", {24'b0, add_b}, 32'h0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Backpressure with a competing request waiting.
    w = '{32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0};
    issue(w.a, w.b, w.sub, w.cin);
    repeat (NC) @(negedge clk);
    chk("bp_valid", {31'b0, resp_valid}, 32'd1);
    op_a = 32'h0000_00FF; op_b = 32'h0000_0001; sub = 1'b0; cin = 1'b0;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {30'b0, resp_valid, req_ready}, 32'h2);
      chk("bp_result", result, w.exp_res);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_idle_gap", {29'b0, resp_valid, req_ready, add_en}, 32'h2);
    @(negedge clk);
    req_valid = 1'b0;
    w = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
    finish_op(w.a, w.cin, w.sub, w);

    // Reset on the 2nd RUN cycle drops the op.
    issue(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", {29'b0, req_ready, add_en, resp_valid}, 32'h4);
    chk("mid_rst_result", result, 32'h0);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        if (resp_valid) seen++;
        @(negedge clk);
      end
      chk("mid_rst_no_resp", seen, 0);
    end
    w = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0};
    run_vec(w);

    // Idle: adder inputs quiet.
    for (int k = 0; k < 10; k++) begin
      chk("idle_adder", {14'b0, add_en, add_ci, add_a, add_b}, 32'h0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
